// File: rtl/reg_rename_file.sv
// reg_rename_file: architectural register file with per-register ROB rename tags
module reg_rename_file #(
  parameter int REG_NUM = 32,
  parameter int XLEN = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic [XLEN-1:0]  rs1_val,
  output logic [XLEN-1:0]  rs2_val,
  output logic [TAG_W-1:0] rs1_rely,
  output logic [TAG_W-1:0] rs2_rely,
  input  logic             dispatch_rdy,
  input  logic [4:0]       dispatch_rd,
  input  logic [TAG_W-1:0] dispatch_tag,
  input  logic             write_rdy,
  input  logic [4:0]       to_rd,
  input  logic [XLEN-1:0]  write_val,
  input  logic [TAG_W-1:0] head_tag
);
  logic [XLEN-1:0]  val [REG_NUM];
  logic [TAG_W-1:0] tag [REG_NUM];
  logic             bp1, bp2, commit, ren;
  always_comb begin
    commit = write_rdy && to_rd != '0;
    ren = dispatch_rdy && dispatch_rd != '0;
    bp1 = commit && to_rd == rs1_addr && tag[rs1_addr] == head_tag;
    bp2 = commit && to_rd == rs2_addr && tag[rs2_addr] == head_tag;
    rs1_val = rs1_addr == '0 ? '0 : bp1 ? write_val : val[rs1_addr];
    rs2_val = rs2_addr == '0 ? '0 : bp2 ? write_val : val[rs2_addr];
    rs1_rely = rs1_addr == '0 || bp1 ? '0 : tag[rs1_addr];
    rs2_rely = rs2_addr == '0 || bp2 ? '0 : tag[rs2_addr];
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val[i] <= '0;
        tag[i] <= '0;
      end
    end else if (rdy_in) begin
      if (commit) val[to_rd] <= write_val;
      if (clear) begin
        for (int i = 0; i < REG_NUM; i++) tag[i] <= '0;
      end else begin
        if (commit && tag[to_rd] == head_tag) tag[to_rd] <= '0;
        if (ren) tag[dispatch_rd] <= dispatch_tag;
      end
    end
  end
endmodule

// File: tb/tb_reg_rename_file.sv
// tb_reg_rename_file: directed and randomized checks of reg_rename_file against a reference model
module tb_reg_rename_file;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear, dispatch_rdy, write_rdy;
  logic [4:0]  rs1_addr, rs2_addr, dispatch_rd, to_rd;
  logic [31:0] rs1_val, rs2_val, write_val;
  logic [4:0]  rs1_rely, rs2_rely, dispatch_tag, head_tag;
  logic [31:0] mv [32];
  logic [4:0]  mt [32];
  int          checks = 0;
  int          fails = 0;
  reg_rename_file dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rs1_rely(rs1_rely), .rs2_rely(rs2_rely),
    .dispatch_rdy(dispatch_rdy), .dispatch_rd(dispatch_rd), .dispatch_tag(dispatch_tag),
    .write_rdy(write_rdy), .to_rd(to_rd), .write_val(write_val), .head_tag(head_tag)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask
  function automatic logic [31:0] ref_val(input logic [4:0] a);
    if (a == 0) return 0;
    if (write_rdy && a == to_rd && mt[a] == head_tag) return write_val;
    return mv[a];
  endfunction
  function automatic logic [4:0] ref_rely(input logic [4:0] a);
    if (a == 0) return 0;
    if (write_rdy && a == to_rd && mt[a] == head_tag) return 0;
    return mt[a];
  endfunction
  task automatic idle();
    rst_in = 0; rdy_in = 1; clear = 0;
    dispatch_rdy = 0; dispatch_rd = 0; dispatch_tag = 0;
    write_rdy = 0; to_rd = 0; write_val = 0; head_tag = 0;
  endtask
  task automatic step(input bit do_chk);
    logic [31:0] nv [32];
    logic [4:0]  nt [32];
    #1;
    if (do_chk) begin
      chk("rs1_val", rs1_val, ref_val(rs1_addr));
      chk("rs1_rely", {27'd0, rs1_rely}, {27'd0, ref_rely(rs1_addr)});
      chk("rs2_val", rs2_val, ref_val(rs2_addr));
      chk("rs2_rely", {27'd0, rs2_rely}, {27'd0, ref_rely(rs2_addr)});
    end
    nv = mv;
    nt = mt;
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin nv[i] = 0; nt[i] = 0; end
    end else if (rdy_in) begin
      if (write_rdy && to_rd != 0) nv[to_rd] = write_val;
      if (clear) begin
        for (int i = 0; i < 32; i++) nt[i] = 0;
      end else begin
        if (write_rdy && to_rd != 0 && mt[to_rd] == head_tag &&
            !(dispatch_rdy && dispatch_rd == to_rd)) nt[to_rd] = 0;
        if (dispatch_rdy && dispatch_rd != 0) nt[dispatch_rd] = dispatch_tag;
      end
    end
    @(posedge clk_in);
    mv = nv;
    mt = nt;
    #1;
  endtask
  task automatic ren(input logic [4:0] rd, input logic [4:0] t);
    idle(); dispatch_rdy = 1; dispatch_rd = rd; dispatch_tag = t; step(1);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) begin mv[i] = 0; mt[i] = 0; end
    idle(); rs1_addr = 5; rs2_addr = 0; rst_in = 1;
    step(0); rst_in = 1; step(0);
    idle(); #1;
    chk("rst_x5_val", rs1_val, 32'd0);
    chk("rst_x5_rely", {27'd0, rs1_rely}, 32'd0);
    step(1);
    dispatch_rdy = 1; dispatch_rd = 5; dispatch_tag = 3; #1;
    chk("pre_rename_rely", {27'd0, rs1_rely}, 32'd0);
    step(1);
    idle(); #1;
    chk("rename_x5_rely", {27'd0, rs1_rely}, 32'd3);
    write_rdy = 1; to_rd = 5; head_tag = 3; write_val = 32'hDEADBEEF; #1;
    chk("bypass_val", rs1_val, 32'hDEADBEEF);
    chk("bypass_rely", {27'd0, rs1_rely}, 32'd0);
    step(1);
    idle(); #1;
    chk("released_rely", {27'd0, rs1_rely}, 32'd0);
    chk("committed_val", rs1_val, 32'hDEADBEEF);
    ren(5, 3); ren(5, 7);
    idle(); write_rdy = 1; to_rd = 5; head_tag = 3; write_val = 32'h11; #1;
    chk("stale_nobypass_rely", {27'd0, rs1_rely}, 32'd7);
    step(1);
    idle(); #1;
    chk("stale_commit_val", rs1_val, 32'h11);
    chk("stale_commit_rely", {27'd0, rs1_rely}, 32'd7);
    ren(6, 2);
    idle(); rs2_addr = 6; write_rdy = 1; to_rd = 6; head_tag = 2; write_val = 32'h66;
    dispatch_rdy = 1; dispatch_rd = 6; dispatch_tag = 9; #1;
    chk("x6_bypass_val", rs2_val, 32'h66);
    step(1);
    idle(); #1;
    chk("x6_val", rs2_val, 32'h66);
    chk("x6_rename_wins", {27'd0, rs2_rely}, 32'd9);
    ren(1, 4); ren(2, 5);
    idle(); clear = 1; write_rdy = 1; to_rd = 1; head_tag = 4; write_val = 32'h42;
    dispatch_rdy = 1; dispatch_rd = 3; dispatch_tag = 6;
    step(1);
    idle(); rs1_addr = 1; rs2_addr = 3; #1;
    chk("clear_x1_val", rs1_val, 32'h42);
    chk("clear_x1_rely", {27'd0, rs1_rely}, 32'd0);
    chk("clear_x3_rely", {27'd0, rs2_rely}, 32'd0);
    rs1_addr = 2; rs2_addr = 6; #1;
    chk("clear_x2_rely", {27'd0, rs1_rely}, 32'd0);
    chk("clear_x6_rely", {27'd0, rs2_rely}, 32'd0);
    ren(7, 8);
    idle(); rs1_addr = 7; rdy_in = 0; dispatch_rdy = 1; dispatch_rd = 7; dispatch_tag = 10;
    write_rdy = 1; to_rd = 7; head_tag = 8; write_val = 32'h77;
    step(1);
    idle(); #1;
    chk("hold_rely", {27'd0, rs1_rely}, 32'd8);
    chk("hold_val", rs1_val, 32'd0);
    write_rdy = 1; to_rd = 0; write_val = 32'h5; dispatch_rdy = 1; dispatch_rd = 0; dispatch_tag = 3;
    step(1);
    idle(); rs1_addr = 0; #1;
    chk("x0_val", rs1_val, 32'd0);
    chk("x0_rely", {27'd0, rs1_rely}, 32'd0);
    for (int n = 0; n < 600; n++) begin
      rst_in = ($urandom_range(0, 99) < 2);
      rdy_in = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 19) == 0);
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 7));
      dispatch_rdy = 1'($urandom);
      dispatch_rd = 5'($urandom_range(0, 7));
      dispatch_tag = 5'($urandom_range(1, 16));
      write_rdy = 1'($urandom);
      to_rd = 5'($urandom_range(0, 7));
      write_val = $urandom;
      head_tag = $urandom_range(0, 1) != 0 ? mt[to_rd] : 5'($urandom_range(0, 16));
      step(1);
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
